mips32_prog_loader: RTL
=======================

Name: mips32_prog_loader

Overview:
- Single-clock bring-up controller for the pipelined MIPS32 core.
- Streams a program image into the unified instruction/data memory and releases the core to run.
- Waits for the core's halt flag, then reads back one result word from data memory.
- Replaces hand-poked memory/PC/HALTED initialisation with a synthesisable load-run-readback sequence.

Parameters:
- ADDR_W, 10, memory word-address width.
- DATA_W, 32, memory/instruction word width.
- TIMEOUT_CYC, 4096, maximum RUN cycles before abort (≥2).

Ports:
- clk1  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- go  in  1  start pulse; sampled only in IDLE.
- load_base  in  ADDR_W  first word address of the image; latched on go.
- result_addr  in  ADDR_W  word address read back after halt; latched on go.
- in_valid  in  1  image word valid.
- in_ready  out  1  loader accepts a word.
- in_data  in  DATA_W  image word.
- in_last  in  1  marks final image word.
- mem_we  out  1  memory write strobe (registered).
- mem_re  out  1  memory read strobe (registered).
- mem_addr  out  ADDR_W  memory word address (registered).
- mem_wdata  out  DATA_W  write data (registered).
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re.
- cpu_start  out  1  one-cycle pulse: core sets PC=0, clears HALTED and TAKEN_BRANCH.
- cpu_run  out  1  high while the core may execute.
- cpu_halted  in  1  core has retired HLT.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_W  word read at result_addr; held until next done.
- words_loaded  out  ADDR_W+1  accepted image words this session.
- err_ovf  out  1  image ran past the top of memory.
- err_timeout  out  1  core did not halt within TIMEOUT_CYC.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset applies at the next edge from any state, including mid-LOAD and mid-RUN; partially written memory is not rolled back.
- IDLE: in_ready=0. On go: latch load_base and result_addr, set wr_ptr=load_base, clear words_loaded, err_ovf, err_timeout; go to LOAD. go is ignored in all other states.
- LOAD: in_ready=1.
  - Handshake = in_valid&in_ready.
  - On each handshake, next cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=in_data; wr_ptr++; words_loaded++.
  - mem_we=0 on cycles with no handshake.
  - in_last with handshake → START.
  - Handshake with wr_ptr == 2^ADDR_W-1 and in_last=0: write that word, set err_ovf, go to DONE. wr_ptr never wraps.
- START: in_ready=0, mem_we=0, cpu_start=1 for exactly one cycle, then RUN.
- RUN: cpu_run=1 and the cycle counter increments.
  - cpu_halted=1 → drop cpu_run, go to READ.
  - Counter reaches TIMEOUT_CYC-1 without halt → drop cpu_run, set err_timeout, go to DONE. result is unchanged.
  - If halt and timeout occur in the same cycle, halt wins.
- READ: mem_re=1, mem_addr=result_addr for one cycle, then RDWAIT.
- RDWAIT: mem_re=0; capture result=mem_rdata, then DONE.
- DONE: done=1 for one cycle; errors and words_loaded are held; return to IDLE.
- cpu_start, mem_we and mem_re are never high together.
- in_ready is high only in LOAD.

Test Plan:
- Factorial image: load_base=0, result_addr=198, 11 words (ADDI…HLT, last word 32'hfc000000) with in_valid held high. Core model halts and holds 5040 at Mem[198]. Expect: 11 mem_we pulses at addresses 0..10 with matching data, one cpu_start pulse, done with result=5040, words_loaded=11, both errors 0.
- Backpressure gaps: same image with in_valid toggling 1-0-0-1. Expect: mem_we only on handshakes, addresses still contiguous 0..10, same final result.
- Overflow: ADDR_W=4, load_base=14, 3 words with in_last on the 3rd. Expect: writes to addresses 14 and 15, err_ovf=1, done, no cpu_start, words_loaded=2.
- Timeout: cpu_halted tied low, TIMEOUT_CYC=16. Expect: cpu_run high for exactly 16 cycles, err_timeout=1, done, no mem_re.
- go while busy: pulse go in LOAD and again in RUN. Expect: latched load_base and result_addr unchanged, no restart.
- Reset mid-LOAD after 5 words: expect all outputs 0 and IDLE at the next edge. A fresh go then loads from the new load_base with words_loaded starting at 0.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// Bring-up sequencer for the pipelined MIPS32 core: streams an image into the
// unified memory, starts the core, waits for HLT and reads back one result word.
module mips32_prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] result_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_start,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W:0]   words_loaded,
  output logic              err_ovf,
  output logic              err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_READ,
    S_RDWAIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   res_addr_q, res_addr_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_to_q, err_to_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      res_addr_q  <= '0;
      words_q     <= '0;
      cnt_q       <= '0;
      err_ovf_q   <= 1'b0;
      err_to_q    <= 1'b0;
      result_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      res_addr_q  <= res_addr_d;
      words_q     <= words_d;
      cnt_q       <= cnt_d;
      err_ovf_q   <= err_ovf_d;
      err_to_q    <= err_to_d;
      result_q    <= result_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    res_addr_d  = res_addr_q;
    words_d     = words_q;
    cnt_d       = cnt_q;
    err_ovf_d   = err_ovf_q;
    err_to_d    = err_to_q;
    result_d    = result_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          wr_ptr_d   = load_base;
          res_addr_d = result_addr;
          words_d    = '0;
          err_ovf_d  = 1'b0;
          err_to_d   = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = in_data;
          words_d     = words_q + (ADDR_W+1)'(1);
          // The pointer saturates at the top word so it can never wrap.
          if (wr_ptr_q != '1) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
          if (in_last) begin
            state_d = S_START;
          end else if (wr_ptr_q == '1) begin
            err_ovf_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_START: begin
        // The last image write is still on the bus for the first START
        // cycle, so the start pulse follows it one cycle later.
        cnt_d = '0;
        if (!mem_we_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cpu_halted) begin
          mem_re_d   = 1'b1;
          mem_addr_d = res_addr_q;
          state_d    = S_READ;
        end else if (cnt_q == CNT_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_READ: begin
        state_d = S_RDWAIT;
      end
      S_RDWAIT: begin
        result_d = mem_rdata;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready     = (state_q == S_LOAD);
  assign cpu_start    = (state_q == S_START) && !mem_we_q;
  assign cpu_run      = (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign mem_we       = mem_we_q;
  assign mem_re       = mem_re_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign result       = result_q;
  assign words_loaded = words_q;
  assign err_ovf      = err_ovf_q;
  assign err_timeout  = err_to_q;

endmodule
